// File: rtl/decode_hazard_ctrl_if.sv
// Decode-side hazard control bundle.
// Decode/writeback/execute drive requests; controller returns steering.
interface decode_hazard_ctrl_if #(
  parameter int STAT_W = 16
);
  logic              dec_valid;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [4:0]        dec_rd;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic              dec_regwrite;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic              branch_taken;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic              issue;
  logic [31:0]       pending;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    output dec_uses_rs1, dec_uses_rs2, dec_regwrite,
    output wb_valid, wb_rd, branch_taken,
    input  stall, bubble, flush, issue,
    input  pending, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  dec_uses_rs1, dec_uses_rs2, dec_regwrite,
    input  wb_valid, wb_rd, branch_taken,
    output stall, bubble, flush, issue,
    output pending, stall_cycles
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode hazard controller: write scoreboard, RAW/WAW stall,
// ID/EX bubble insertion and multi-cycle flush after taken branch.
module decode_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2,
  parameter int STAT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  decode_hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        fcnt_q;
  logic [CNT_W-1:0]  cnt_q [32];
  logic [STAT_W-1:0] stat_q;

  logic        raw1;
  logic        raw2;
  logic        waw;
  logic        hazard;
  logic        flushing;
  logic        stall;
  logic        issue;
  logic        inc;
  logic        dec;
  logic [31:0] inc_v;
  logic [31:0] dec_v;
  logic [31:0] pend;

  assign raw1 = bus.dec_uses_rs1
             && (bus.dec_rs1 != 5'd0)
             && (cnt_q[bus.dec_rs1] != '0);
  assign raw2 = bus.dec_uses_rs2
             && (bus.dec_rs2 != 5'd0)
             && (cnt_q[bus.dec_rs2] != '0);
  assign waw  = bus.dec_regwrite
             && (bus.dec_rd != 5'd0)
             && (cnt_q[bus.dec_rd] == CNT_MAX);

  assign hazard   = bus.dec_valid && (raw1 || raw2 || waw);
  assign flushing = bus.branch_taken || (state_q == FLUSH);
  assign stall    = hazard && !flushing;
  assign issue    = bus.dec_valid && !hazard && !flushing;

  assign inc = issue && bus.dec_regwrite
            && (bus.dec_rd != 5'd0);
  assign dec = bus.wb_valid && (bus.wb_rd != 5'd0);

  assign bus.stall  = !reset_i && stall;
  assign bus.bubble = !reset_i && (flushing || hazard);
  assign bus.flush  = !reset_i && flushing;
  assign bus.issue  = !reset_i && issue;
  assign bus.pending = reset_i ? '0 : pend;
  assign bus.stall_cycles = reset_i ? '0 : stat_q;

  // One-hot increment/decrement selects per architectural register
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (inc) inc_v[bus.dec_rd] = 1'b1;
    if (dec) dec_v[bus.wb_rd] = 1'b1;
    inc_v[0] = 1'b0;
    dec_v[0] = 1'b0;
  end

  // Pending view of the registered counters, x0 never tracked
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++) begin
      pend[r] = (cnt_q[r] != '0);
    end
  end

  // Run/flush sequencing; a taken branch always reloads the window
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else if (bus.branch_taken) begin
      state_q <= (FLUSH_LOAD != 4'd0) ? FLUSH : RUN;
      fcnt_q  <= FLUSH_LOAD;
    end else if (state_q == FLUSH) begin
      if (fcnt_q <= 4'd1) begin
        state_q <= RUN;
        fcnt_q  <= '0;
      end else begin
        fcnt_q  <= fcnt_q - 4'd1;
      end
    end
  end

  // In-flight write counters; stray retire of an idle reg is dropped
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_v[r] && !dec_v[r]) begin
          cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        end else if (dec_v[r] && !inc_v[r]
                     && (cnt_q[r] != '0)) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // Saturating count of stalled decode cycles
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_q <= '0;
    end else if (stall && (stat_q != '1)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl.
// Directed scenarios plus randomized traffic against a counter model.
module tb_decode_hazard_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 2;
  localparam int SW   = 16;
  localparam int MAXC = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk_i;
  logic reset_i;
  int   checks;
  int   failures;

  int m_cnt [32];
  int m_frem;
  int m_stat;

  decode_hazard_ctrl_if #(.STAT_W(SW)) bus ();

  decode_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .CNT_W(CW),
    .STAT_W(SW)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic m_hazard();
    logic h;
    h = 1'b0;
    if (bus.dec_uses_rs1 && bus.dec_rs1 != 0
        && m_cnt[bus.dec_rs1] > 0) h = 1'b1;
    if (bus.dec_uses_rs2 && bus.dec_rs2 != 0
        && m_cnt[bus.dec_rs2] > 0) h = 1'b1;
    if (bus.dec_regwrite && bus.dec_rd != 0
        && m_cnt[bus.dec_rd] == MAXC) h = 1'b1;
    return bus.dec_valid && h;
  endfunction

  function automatic logic m_flushing();
    return bus.branch_taken || (m_frem > 0);
  endfunction

  function automatic logic [3:0] m_ctl();
    logic s, b, f, i;
    s = !reset_i && !m_flushing() && m_hazard();
    b = !reset_i && (m_flushing() || m_hazard());
    f = !reset_i && m_flushing();
    i = !reset_i && !m_flushing() && bus.dec_valid
        && !m_hazard();
    return {s, b, f, i};
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] > 0);
    return reset_i ? 32'h0 : p;
  endfunction

  task automatic set_idle();
    bus.dec_valid    = 1'b0;
    bus.dec_rs1      = 5'd0;
    bus.dec_rs2      = 5'd0;
    bus.dec_rd       = 5'd0;
    bus.dec_uses_rs1 = 1'b0;
    bus.dec_uses_rs2 = 1'b0;
    bus.dec_regwrite = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic drv_write(input int rd);
    bus.dec_valid    = 1'b1;
    bus.dec_regwrite = 1'b1;
    bus.dec_rd       = 5'(rd);
    bus.dec_uses_rs1 = 1'b0;
    bus.dec_uses_rs2 = 1'b0;
  endtask

  task automatic drv_read(input int rs);
    bus.dec_valid    = 1'b1;
    bus.dec_regwrite = 1'b0;
    bus.dec_rs1      = 5'(rs);
    bus.dec_uses_rs1 = 1'b1;
    bus.dec_uses_rs2 = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] c;
    int ir, dr;
    c = m_ctl();
    if (reset_i) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_frem = 0;
      m_stat = 0;
    end else begin
      if (bus.branch_taken) m_frem = FC - 1;
      else if (m_frem > 0) m_frem--;
      if (c[3] && m_stat < SMAX) m_stat++;
      ir = (c[0] && bus.dec_regwrite && bus.dec_rd != 0)
           ? int'(bus.dec_rd) : -1;
      dr = (bus.wb_valid && bus.wb_rd != 0)
           ? int'(bus.wb_rd) : -1;
      if (!(ir >= 0 && ir == dr)) begin
        if (ir >= 0) m_cnt[ir]++;
        if (dr >= 0 && m_cnt[dr] > 0) m_cnt[dr]--;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    reset_i = 1'b1;
    set_idle();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    drv_write(3);
    @(negedge clk_i);
    checks++;
    if (bus.issue !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_issue got=%b exp=1", bus.issue);
    end
    tick();
    drv_write(10);
    tick();
    set_idle();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0000_0408) begin
      failures++;
      $display("FAIL rst_pre_pend got=%h exp=00000408",
               bus.pending);
    end
    reset_i = 1'b1;
    drv_read(3);
    bus.branch_taken = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({bus.stall, bus.bubble, bus.flush, bus.issue,
         bus.pending, bus.stall_cycles} !== '0) begin
      failures++;
      $display("FAIL rst_outs_zero got=%b%b%b%b %h %h exp=0",
               bus.stall, bus.bubble, bus.flush, bus.issue,
               bus.pending, bus.stall_cycles);
    end
    tick();
    reset_i = 1'b0;
    set_idle();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0 || bus.stall_cycles !== '0
        || bus.flush !== 1'b0) begin
      failures++;
      $display("FAIL rst_after got=%h %h %b exp=0 0 0",
               bus.pending, bus.stall_cycles, bus.flush);
    end
    drv_read(5);
    @(negedge clk_i);
    checks++;
    if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_first_issue got=%b/%b exp=1/0",
               bus.issue, bus.stall);
    end
    tick();
    set_idle();
  endtask

  task automatic test_raw_stall();
    reset_dut();
    drv_write(3);
    tick();
    drv_read(3);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
      end
      @(negedge clk_i);
      checks++;
      if ({bus.stall, bus.bubble, bus.issue} !== 3'b110) begin
        failures++;
        $display("FAIL raw_stall_%0d got=%b%b%b exp=110", k,
                 bus.stall, bus.bubble, bus.issue);
      end
      tick();
    end
    bus.wb_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.issue !== 1'b1 || bus.stall !== 1'b0
        || bus.stall_cycles !== 16'd3) begin
      failures++;
      $display("FAIL raw_release got=%b/%b cyc=%0d exp=1/0 3",
               bus.issue, bus.stall, bus.stall_cycles);
    end
    tick();
    set_idle();
  endtask

  task automatic test_x0();
    reset_dut();
    for (int r = 1; r < 32; r++) begin
      drv_write(r);
      tick();
    end
    set_idle();
    bus.dec_valid    = 1'b1;
    bus.dec_uses_rs1 = 1'b1;
    bus.dec_uses_rs2 = 1'b1;
    bus.dec_regwrite = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'hFFFF_FFFE || bus.stall !== 1'b0
        || bus.issue !== 1'b1) begin
      failures++;
      $display("FAIL x0_nostall got=%h %b/%b exp=fffffffe 0/1",
               bus.pending, bus.stall, bus.issue);
    end
    tick();
    set_idle();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL x0_pend got=%h exp=fffffffe", bus.pending);
    end
    drv_read(17);
    @(negedge clk_i);
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL x0_r17_stall got=%b exp=1", bus.stall);
    end
    tick();
    set_idle();
  endtask

  task automatic test_waw();
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      drv_write(7);
      @(negedge clk_i);
      checks++;
      if (bus.issue !== 1'b1) begin
        failures++;
        $display("FAIL waw_issue_%0d got=%b exp=1", k, bus.issue);
      end
      tick();
    end
    @(negedge clk_i);
    checks++;
    if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin
      failures++;
      $display("FAIL waw_full got=%b/%b exp=1/0",
               bus.stall, bus.issue);
    end
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    @(negedge clk_i);
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL waw_same_wb got=%b exp=1", bus.stall);
    end
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL waw_release got=%b/%b exp=1/0",
               bus.issue, bus.stall);
    end
    tick();
    set_idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    repeat (2) tick();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0000_0080) begin
      failures++;
      $display("FAIL waw_left1 got=%h exp=00000080", bus.pending);
    end
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0) begin
      failures++;
      $display("FAIL waw_drain got=%h exp=0", bus.pending);
    end
  endtask

  task automatic test_branch_flush();
    logic [2:0] exp_sbf [4];
    exp_sbf[0] = 3'b011;
    exp_sbf[1] = 3'b011;
    exp_sbf[2] = 3'b110;
    exp_sbf[3] = 3'b110;
    reset_dut();
    drv_write(3);
    tick();
    drv_read(3);
    @(negedge clk_i);
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL br_pre_stall got=%b exp=1", bus.stall);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.branch_taken = (k == 0);
      @(negedge clk_i);
      checks++;
      if ({bus.stall, bus.bubble, bus.flush} !== exp_sbf[k]
          || (k < 2 && bus.issue !== 1'b0)) begin
        failures++;
        $display("FAIL br_flush_%0d got=%b%b%b exp=%b", k,
                 bus.stall, bus.bubble, bus.flush, exp_sbf[k]);
      end
      tick();
    end
    drv_write(20);
    for (int k = 0; k < 4; k++) begin
      bus.branch_taken = (k == 0 || k == 1);
      @(negedge clk_i);
      checks++;
      if (bus.flush !== (k < 3) || bus.stall !== 1'b0
          || bus.issue !== (k == 3)) begin
        failures++;
        $display("FAIL br_reload_%0d got=%b/%b/%b exp=%b/0/%b",
                 k, bus.flush, bus.stall, bus.issue,
                 (k < 3), (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (bus.pending !== 32'h0000_0008) begin
          failures++;
          $display("FAIL br_sb_untouched got=%h exp=00000008",
                   bus.pending);
        end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_same_cycle();
    reset_dut();
    drv_write(9);
    tick();
    drv_write(9);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    @(negedge clk_i);
    checks++;
    if (bus.issue !== 1'b1) begin
      failures++;
      $display("FAIL same_issue got=%b exp=1", bus.issue);
    end
    tick();
    set_idle();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0000_0200) begin
      failures++;
      $display("FAIL same_pend got=%h exp=00000200", bus.pending);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    tick();
    bus.wb_rd = 5'd4;
    tick();
    set_idle();
    drv_write(4);
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0) begin
      failures++;
      $display("FAIL stray_wb got=%h exp=0", bus.pending);
    end
    tick();
    set_idle();
    @(negedge clk_i);
    checks++;
    if (bus.pending !== 32'h0000_0010) begin
      failures++;
      $display("FAIL stray_nowrap got=%h exp=00000010",
               bus.pending);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    tick();
    set_idle();
  endtask

  task automatic test_random();
    logic [3:0] ec;
    int q [$];
    int shown;
    shown = 0;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      reset_i          = ($urandom_range(0, 199) == 0);
      bus.dec_valid    = ($urandom_range(0, 9) < 7);
      bus.dec_rs1      = 5'($urandom_range(0, 7));
      bus.dec_rs2      = 5'($urandom_range(0, 7));
      bus.dec_rd       = 5'($urandom_range(0, 7));
      bus.dec_uses_rs1 = 1'($urandom_range(0, 1));
      bus.dec_uses_rs2 = 1'($urandom_range(0, 1));
      bus.dec_regwrite = ($urandom_range(0, 3) != 0);
      bus.branch_taken = ($urandom_range(0, 19) == 0);
      q.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r);
      bus.wb_valid = 1'b0;
      bus.wb_rd    = 5'd0;
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'($urandom_range(0, 31));
      end
      @(negedge clk_i);
      ec = m_ctl();
      checks++;
      if ({bus.stall, bus.bubble, bus.flush, bus.issue} !== ec
          || bus.pending !== m_pending()
          || bus.stall_cycles !== (reset_i ? 16'd0 : 16'(m_stat)))
      begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_%0d got=%b%b%b%b %h %0d exp=%b %h %0d",
                   n, bus.stall, bus.bubble, bus.flush, bus.issue,
                   bus.pending, bus.stall_cycles, ec, m_pending(),
                   reset_i ? 0 : m_stat);
        end
      end
      tick();
    end
    reset_i = 1'b0;
    set_idle();
  endtask

  task automatic test_stat_saturate();
    reset_dut();
    drv_write(5);
    tick();
    drv_read(5);
    repeat (100) tick();
    @(negedge clk_i);
    checks++;
    if (bus.stall_cycles !== 16'd100) begin
      failures++;
      $display("FAIL stat_100 got=%0d exp=100", bus.stall_cycles);
    end
    repeat (SMAX + 6 - 100) tick();
    @(negedge clk_i);
    checks++;
    if (bus.stall_cycles !== 16'hFFFF || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL stat_sat got=%h exp=ffff", bus.stall_cycles);
    end
    set_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_frem   = 0;
    m_stat   = 0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    reset_i = 1'b1;
    set_idle();
    tick();
    tick();
    test_reset();
    test_raw_stall();
    test_x0();
    test_waw();
    test_branch_flush();
    test_same_cycle();
    test_random();
    test_stat_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
